stage_buffer_skid: RTL and testbench



---
 rtl/stage_buffer_skid_if.sv | 23 ++
 rtl/stage_buffer_skid.sv | 105 ++++++++++
 tb/tb_stage_buffer_skid.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/stage_buffer_skid_if.sv
// Stage handshake bundle: upstream data/valid/ready, downstream data/valid, and the STALL/KILL controls.
// The slave modport is the stage buffer; the master modport is the surrounding pipeline.
interface stage_buffer_skid_if #(
    parameter int W = 16
);
    logic [W-1:0] I;
    logic         IN_VALID;
    logic         IN_READY;
    logic         STALL;
    logic         KILL;
    logic [W-1:0] O;
    logic         OUT_VALID;

    modport master (
        output I, IN_VALID, STALL, KILL,
        input  IN_READY, O, OUT_VALID
    );

    modport slave (
        input  I, IN_VALID, STALL, KILL,
        output IN_READY, O, OUT_VALID
    );
endinterface

// File: rtl/stage_buffer_skid.sv
// Single-entry pipeline stage with a registered upstream ready and one skid slot; KILL flushes to the NOP bubble.
// Optional saturating STALL/KILL counters are built only when STAGE_BUFFER_STATS_EN is defined.
module stage_buffer_skid #(
    parameter int           W   = 16,
    parameter logic [W-1:0] NOP = {W{1'b1}},
    parameter int           CW  = 16
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    stage_buffer_skid_if.slave    bus,
    output logic [CW-1:0]         STALL_CNT,
    output logic [CW-1:0]         KILL_CNT
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t       state;
    logic [W-1:0] main_q;
    logic [W-1:0] skid_q;
    logic         rdy_q;
    logic         vld_q;
    logic         accept;
    logic         drain;

    // Ready is a flop, so accept never depends combinationally on STALL.
    assign accept = bus.IN_VALID & rdy_q;
    assign drain  = vld_q & ~bus.STALL;

    always_ff @(posedge CLK) begin
        if (!RST_N || bus.KILL) begin
            state  <= EMPTY;
            main_q <= NOP;
            skid_q <= NOP;
            rdy_q  <= 1'b1;
            vld_q  <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state  <= ONE;
                        main_q <= bus.I;
                        vld_q  <= 1'b1;
                    end
                end
                ONE: begin
                    if (accept && drain) begin
                        main_q <= bus.I;
                    end else if (accept) begin
                        state  <= TWO;
                        skid_q <= bus.I;
                        rdy_q  <= 1'b0;
                    end else if (drain) begin
                        state  <= EMPTY;
                        main_q <= NOP;
                        vld_q  <= 1'b0;
                    end
                end
                TWO: begin
                    if (drain) begin
                        state  <= ONE;
                        main_q <= skid_q;
                        skid_q <= NOP;
                        rdy_q  <= 1'b1;
                    end
                end
                default: begin
                    state  <= EMPTY;
                    main_q <= NOP;
                    skid_q <= NOP;
                    rdy_q  <= 1'b1;
                    vld_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.O         = main_q;
    assign bus.OUT_VALID = vld_q;
    assign bus.IN_READY  = rdy_q;

`ifdef STAGE_BUFFER_STATS_EN
    logic [CW-1:0] stall_cnt_q;
    logic [CW-1:0] kill_cnt_q;

    // Counters saturate at all-ones and only reset clears them.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            stall_cnt_q <= '0;
            kill_cnt_q  <= '0;
        end else begin
            if (vld_q && bus.STALL && !bus.KILL && stall_cnt_q != '1)
                stall_cnt_q <= stall_cnt_q + CW'(1);
            if (bus.KILL && kill_cnt_q != '1)
                kill_cnt_q <= kill_cnt_q + CW'(1);
        end
    end

    assign STALL_CNT = stall_cnt_q;
    assign KILL_CNT  = kill_cnt_q;
`else
    assign STALL_CNT = '0;
    assign KILL_CNT  = '0;
`endif

endmodule

// File: tb/tb_stage_buffer_skid.sv
// Bench for stage_buffer_skid: a queue holds the words the stage should contain (front = O);
// every cycle the DUT outputs and counters are compared against it.
module tb_stage_buffer_skid;
    localparam int W  = 16;
    localparam int CW = 4;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic [CW-1:0] STALL_CNT;
    logic [CW-1:0] KILL_CNT;

    stage_buffer_skid_if #(.W(W)) bus ();

    stage_buffer_skid #(.W(W), .NOP(16'hFFFF), .CW(CW)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .bus       (bus),
        .STALL_CNT (STALL_CNT),
        .KILL_CNT  (KILL_CNT)
    );

    always #5 CLK = ~CLK;

    logic [W-1:0] mq[$];
    logic         mrdy = 1'b1;
    int           ms   = 0;
    int           mk   = 0;
    int           n_cmp = 0;
    int           n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", tag, act, exp, $time);
        end
    endtask

    // Advance one clock, update the reference, then compare on the falling edge.
    task automatic step(input string tag);
        logic acc;
        logic [W-1:0] exp_o;
        int exp_s, exp_k;
        @(posedge CLK);
        if (!RST_N) begin
            mq.delete();
            mrdy = 1'b1;
            ms = 0;
            mk = 0;
        end else begin
            if (mq.size() != 0 && bus.STALL && !bus.KILL && ms != 15) ms++;
            if (bus.KILL && mk != 15) mk++;
            if (bus.KILL) begin
                mq.delete();
                mrdy = 1'b1;
            end else begin
                acc = bus.IN_VALID && mrdy;
                if (mq.size() != 0 && !bus.STALL) void'(mq.pop_front());
                if (acc) mq.push_back(bus.I);
                mrdy = (mq.size() < 2);
            end
        end
        @(negedge CLK);
        exp_o = (mq.size() != 0) ? mq[0] : 16'hFFFF;
`ifdef STAGE_BUFFER_STATS_EN
        exp_s = ms;
        exp_k = mk;
`else
        exp_s = 0;
        exp_k = 0;
`endif
        chk({tag, ".o"},     32'(bus.O),         32'(exp_o));
        chk({tag, ".vld"},   32'(bus.OUT_VALID), 32'(mq.size() != 0));
        chk({tag, ".rdy"},   32'(bus.IN_READY),  32'(mrdy));
        chk({tag, ".scnt"},  32'(STALL_CNT),     32'(exp_s));
        chk({tag, ".kcnt"},  32'(KILL_CNT),      32'(exp_k));
    endtask

    task automatic drive(input logic v, input logic [W-1:0] d, input logic s, input logic k);
        bus.IN_VALID = v;
        bus.I        = d;
        bus.STALL    = s;
        bus.KILL     = k;
    endtask

    initial begin
        RST_N = 1'b0;
        drive(1'b1, 16'h1234, 1'b0, 1'b0);
        step("rst");
        step("rst");
        RST_N = 1'b1;
        drive(1'b0, 16'h1234, 1'b0, 1'b0);
        step("rst_rel");

        for (int k = 1; k <= 5; k++) begin
            drive(1'b1, W'(k), 1'b0, 1'b0);
            step("stream");
        end
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        step("stream_tail");
        step("stream_tail");

        drive(1'b1, 16'h00A0, 1'b0, 1'b0);
        step("skid_a");
        drive(1'b1, 16'h00B0, 1'b1, 1'b0);
        step("skid_b");
        drive(1'b1, 16'h00C0, 1'b1, 1'b0);
        step("skid_hold");
        step("skid_hold");
        drive(1'b1, 16'h00C0, 1'b0, 1'b0);
        step("skid_rel");
        step("skid_c");
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        step("skid_tail");
        step("skid_tail");

        drive(1'b1, 16'h0011, 1'b0, 1'b0);
        step("kill_fill");
        drive(1'b1, 16'h0022, 1'b1, 1'b0);
        step("kill_fill");
        drive(1'b1, 16'h0033, 1'b1, 1'b1);
        step("kill");
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        step("kill_after");
        step("kill_after");

        drive(1'b1, 16'h0011, 1'b0, 1'b0);
        step("mrst_fill");
        drive(1'b1, 16'h0022, 1'b1, 1'b0);
        step("mrst_fill");
        drive(1'b1, 16'h0033, 1'b1, 1'b0);
        RST_N = 1'b0;
        step("mrst");
        RST_N = 1'b1;
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        step("mrst_after");

        drive(1'b1, 16'h0055, 1'b0, 1'b0);
        step("stat_fill");
        drive(1'b0, 16'h0000, 1'b1, 1'b0);
        for (int k = 0; k < 20; k++) step("stat_stall");
        drive(1'b0, 16'h0000, 1'b0, 1'b1);
        step("stat_kill");
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        step("stat_idle");
        drive(1'b0, 16'h0000, 1'b0, 1'b1);
        step("stat_kill");
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        step("stat_idle");

        for (int k = 0; k < 300; k++) begin
            drive(1'($urandom_range(0, 3) != 0), W'($urandom_range(0, 16'hFFFE)),
                  1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 31) == 0));
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
